ccir_stream_packer: RTL and testbench

- Parametrised CCIR601-style byte-stream source that replaces the bench-only file feeder in front of motion_detection_top.
- Accepts planar luma and interleaved chroma (Cb,Cr pairs) over valid/ready handshakes.
- Emits the Y,Cb,Y,Cr byte sequence on dout/dstrb at one component per CLK_DIV clocks.
- Optionally upsamples 4:2:0 chroma to 4:2:2 by replaying each even line's chroma, stored in an internal line buffer, on the following odd line.

---
 rtl/ccir_stream_packer.sv | 175 +++++++++++++++++
 tb/tb_ccir_stream_packer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ccir_stream_packer.sv
// rtl/ccir_stream_packer.sv - CCIR601 Y,Cb,Y,Cr byte-stream source with optional 4:2:0 to 4:2:2 chroma replay
module ccir_stream_packer #(
  parameter int FRAME_WIDTH  = 144,
  parameter int FRAME_HEIGHT = 80,
  parameter int CLK_DIV      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       mode420,
  input  logic [7:0] y_data,
  input  logic       y_valid,
  output logic       y_ready,
  input  logic [7:0] c_data,
  input  logic       c_valid,
  output logic       c_ready,
  output logic [7:0] dout,
  output logic       dstrb,
  output logic       dclr,
  output logic       frame_done,
  output logic       underrun
);

  localparam int PAIRS = FRAME_WIDTH / 2;
  localparam int XW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int YW    = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW    = XW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [1:0] PH_Y0 = 2'd0;
  localparam logic [1:0] PH_CR = 2'd3;

  localparam logic [XW-1:0] X_LAST   = XW'(PAIRS - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(FRAME_HEIGHT - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [DW-1:0] div_q, div_d;
  logic          mode_q, mode_d;
  logic [7:0]    dout_q, dout_d;
  logic          dstrb_q, dstrb_d;
  logic          dclr_q, dclr_d;
  logic          fdone_q, fdone_d;
  logic          fpend_q, fpend_d;
  logic          underrun_q, underrun_d;

  logic [7:0]    lbuf [FRAME_WIDTH];
  logic [7:0]    rd_q;

  logic          is_chroma, replay, slot, y_rdy, c_rdy, hs;
  logic          line_start, frame_start, wr_en;
  logic [7:0]    fetch_byte;
  logic [AW-1:0] buf_addr;

  // phase[0] marks a chroma slot, phase[1] selects Cr over Cb within the pair
  assign is_chroma   = phase_q[0];
  assign replay      = is_chroma & mode_q & y_q[0];
  assign slot        = (state_q == S_FETCH) | ((state_q == S_HOLD) & (div_q == DIV_LAST));
  assign y_rdy       = ena & slot & ~is_chroma;
  assign c_rdy       = ena & slot & is_chroma & ~replay;
  assign hs          = (y_rdy & y_valid) | (c_rdy & c_valid) | (ena & slot & replay);
  assign fetch_byte  = is_chroma ? (replay ? rd_q : c_data) : y_data;
  assign line_start  = (phase_q == PH_Y0) && (x_q == '0);
  assign frame_start = line_start && (y_q == '0);
  assign buf_addr    = {x_q, phase_q[1]};
  assign wr_en       = ena & c_rdy & c_valid & mode_q & ~y_q[0];

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    x_d        = x_q;
    y_d        = y_q;
    div_d      = div_q;
    mode_d     = mode_q;
    dout_d     = dout_q;
    dstrb_d    = 1'b0;
    dclr_d     = 1'b0;
    fdone_d    = 1'b0;
    fpend_d    = fpend_q;
    underrun_d = underrun_q;
    if (ena) begin
      case (state_q)
        S_IDLE:  state_d = S_FETCH;
        S_FETCH: if (!hs && !line_start) underrun_d = 1'b1;
        S_HOLD: begin
          if (div_q != DIV_LAST) begin
            div_d = div_q + 1'b1;
          end else begin
            if (fpend_q) begin
              fdone_d = 1'b1;
              fpend_d = 1'b0;
            end
            if (!hs) state_d = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (slot && frame_start) mode_d = mode420;
      if (hs) begin
        dout_d  = fetch_byte;
        dstrb_d = 1'b1;
        dclr_d  = frame_start;
        div_d   = '0;
        state_d = S_HOLD;
        phase_d = phase_q + 2'd1;
        if (phase_q == PH_CR) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              fpend_d = 1'b1;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_Y0;
      x_q        <= '0;
      y_q        <= '0;
      div_q      <= '0;
      mode_q     <= 1'b0;
      dout_q     <= 8'd0;
      dstrb_q    <= 1'b0;
      dclr_q     <= 1'b0;
      fdone_q    <= 1'b0;
      fpend_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      x_q        <= x_d;
      y_q        <= y_d;
      div_q      <= div_d;
      mode_q     <= mode_d;
      dout_q     <= dout_d;
      dstrb_q    <= dstrb_d;
      dclr_q     <= dclr_d;
      fdone_q    <= fdone_d;
      fpend_q    <= fpend_d;
      underrun_q <= underrun_d;
    end
  end

  // Prefetch the next chroma byte while the preceding Y slot is pending,
  // so a replayed chroma slot is served with no extra latency.
  always_ff @(posedge clk) begin
    if (wr_en) lbuf[buf_addr] <= c_data;
    if (ena && !is_chroma) rd_q <= lbuf[buf_addr];
  end

  assign y_ready    = y_rdy;
  assign c_ready    = c_rdy;
  assign dout       = dout_q;
  assign dstrb      = dstrb_q & ena;
  assign dclr       = dclr_q & ena;
  assign frame_done = fdone_q & ena;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_ccir_stream_packer.sv
// tb/tb_ccir_stream_packer.sv - directed bench for ccir_stream_packer (4x2 frames, CLK_DIV 1/2/3)
module tb_ccir_stream_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ena, mode420, y_valid, c_valid;
  logic [7:0] y_data, c_data;
  logic       y_ready, c_ready, dstrb, dclr, frame_done, underrun;
  logic [7:0] dout;

  logic [7:0] k_y = 8'h55;
  logic [7:0] k_c = 8'hAA;
  logic       k_v = 1'b1;
  logic       y_ready1, c_ready1, dstrb1, dclr1, fd1, ur1;
  logic       y_ready3, c_ready3, dstrb3, dclr3, fd3, ur3;
  logic [7:0] dout1, dout3;

  ccir_stream_packer #(.FRAME_WIDTH(4), .FRAME_HEIGHT(2), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .ena(ena), .mode420(mode420),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
    .dout(dout), .dstrb(dstrb), .dclr(dclr), .frame_done(frame_done), .underrun(underrun));

  ccir_stream_packer #(.FRAME_WIDTH(4), .FRAME_HEIGHT(2), .CLK_DIV(1)) u1 (
    .clk(clk), .rst(rst), .ena(ena), .mode420(mode420),
    .y_data(k_y), .y_valid(k_v), .y_ready(y_ready1),
    .c_data(k_c), .c_valid(k_v), .c_ready(c_ready1),
    .dout(dout1), .dstrb(dstrb1), .dclr(dclr1), .frame_done(fd1), .underrun(ur1));

  ccir_stream_packer #(.FRAME_WIDTH(4), .FRAME_HEIGHT(2), .CLK_DIV(3)) u3 (
    .clk(clk), .rst(rst), .ena(ena), .mode420(mode420),
    .y_data(k_y), .y_valid(k_v), .y_ready(y_ready3),
    .c_data(k_c), .c_valid(k_v), .c_ready(c_ready3),
    .dout(dout3), .dstrb(dstrb3), .dclr(dclr3), .frame_done(fd3), .underrun(ur3));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc, ycnt, ccnt, crdy_line1;
  bit c_once;
  int outq[$], strbq[$], dclrq[$], fdq[$];
  int mon, u1_bad, u3_bad, u3_last, u3_n;
  logic [7:0] u1_prev, u3_prev;
  int pause_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int out_at(input int i);
    return (i < outq.size()) ? outq[i] : -1;
  endfunction

  function automatic int strb_at(input int i);
    return (i < strbq.size()) ? strbq[i] : -1000;
  endfunction

  function automatic int exp_byte(input int i);
    int k;
    k = i % 8;
    return (k % 2 == 1) ? 80 + k / 2 : 10 + k / 2;
  endfunction

  task automatic drive_data();
    y_data = 8'(10 + ycnt % 4);
    c_data = (c_once && ccnt >= 4) ? 8'hEE : 8'(80 + ccnt % 4);
  endtask

  task automatic tick();
    logic hy, hc;
    @(negedge clk);
    cyc++;
    if (dstrb) begin
      outq.push_back(int'(dout));
      strbq.push_back(cyc);
    end
    if (dclr) dclrq.push_back(cyc);
    if (frame_done) fdq.push_back(cyc);
    if (c_ready && outq.size() >= 8 && outq.size() < 16) crdy_line1++;
    if (mon == 1) begin
      u1_prev = dout1;
      u3_prev = dout3;
      u3_last = -1;
      mon = 2;
    end else if (mon == 2) begin
      if (!dstrb1 || !(y_ready1 || c_ready1) || dout1 == u1_prev) u1_bad++;
      u1_prev = dout1;
      if (dstrb3) begin
        if (u3_last >= 0 && cyc - u3_last != 3) u3_bad++;
        u3_last = cyc;
        u3_n++;
      end else if (dout3 != u3_prev) begin
        u3_bad++;
      end
      u3_prev = dout3;
    end
    hy = y_valid & y_ready;
    hc = c_valid & c_ready;
    @(posedge clk);
    #1;
    if (hy) ycnt++;
    if (hc) ccnt++;
    drive_data();
  endtask

  task automatic run_until(input int n, input int bound);
    int k;
    k = 0;
    while (outq.size() < n && k < bound) begin
      tick();
      k++;
    end
    if (outq.size() < n) check("timeout_strobes", outq.size(), n);
  endtask

  task automatic do_reset(input bit m420);
    rst = 1'b0; ena = 1'b0; y_valid = 1'b0; c_valid = 1'b0; mode420 = m420;
    tick();
    tick();
    outq.delete(); strbq.delete(); dclrq.delete(); fdq.delete();
    cyc = 0; ycnt = 0; ccnt = 0; crdy_line1 = 0; c_once = m420;
    drive_data();
    rst = 1'b1; ena = 1'b1; y_valid = 1'b1; c_valid = 1'b1;
  endtask

  task automatic gap_check(input string tag, input int first, input int last, input int gap);
    int bad;
    bad = 0;
    for (int i = first; i <= last; i++)
      if (strb_at(i) - strb_at(i - 1) != gap) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    rst = 1'b0; ena = 1'b1; mode420 = 1'b0; y_valid = 1'b1; c_valid = 1'b1;
    ycnt = 0; ccnt = 0; cyc = 0; c_once = 1'b0; mon = 0;
    u1_bad = 0; u3_bad = 0; u3_n = 0; u3_last = -1; crdy_line1 = 0;
    drive_data();
    tick();
    tick();
    check("rst_dout", dout, 0);
    check("rst_dstrb", dstrb, 0);
    check("rst_dclr", dclr, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_underrun", underrun, 0);
    check("rst_y_ready", y_ready, 0);
    check("rst_c_ready", c_ready, 0);

    // 4:2:2 passthrough frame, plus CLK_DIV=1 and CLK_DIV=3 instances alongside
    do_reset(1'b0);
    repeat (3) tick();
    mon = 1;
    run_until(17, 200);
    mon = 0;
    for (int i = 0; i < 16; i++) check($sformatf("t1_byte%0d", i), out_at(i), exp_byte(i));
    gap_check("t1_period", 1, 16, 2);
    check("t1_first_strobe", strb_at(0), 3);
    check("t1_dclr_count", dclrq.size(), 2);
    if (dclrq.size() > 0) check("t1_dclr_first", dclrq[0], strb_at(0));
    check("t1_fd_count", fdq.size(), 1);
    if (fdq.size() > 0) check("t1_fd_cycle", fdq[0], strb_at(15) + 2);
    if (dclrq.size() > 1 && fdq.size() > 0) check("t1_dclr_with_fd", dclrq[1], fdq[0]);
    check("t1_byte16", out_at(16), 10);
    check("t1_underrun", underrun, 0);
    check("div1_every_cycle", u1_bad, 0);
    check("div3_spacing", u3_bad, 0);
    check("div3_strobes", (u3_n >= 8) ? 1 : 0, 1);

    // ena low for 4 cycles during a hold
    do_reset(1'b0);
    run_until(3, 50);
    ena = 1'b0;
    pause_bad = 0;
    repeat (4) begin
      tick();
      if (dstrb || dout != 8'd11 || y_ready || c_ready || dclr) pause_bad++;
    end
    ena = 1'b1;
    check("ena_pause_frozen", pause_bad, 0);
    run_until(5, 50);
    check("ena_gap", strb_at(3) - strb_at(2), 6);
    check("ena_resume_byte", out_at(3), 81);
    check("ena_next_period", strb_at(4) - strb_at(3), 2);
    check("ena_underrun", underrun, 0);

    // luma starvation at a line start is legal
    do_reset(1'b0);
    run_until(8, 50);
    y_valid = 1'b0;
    repeat (5) tick();
    y_valid = 1'b1;
    run_until(10, 50);
    check("linestart_gap", strb_at(8) - strb_at(7), 7);
    check("linestart_byte", out_at(8), 10);
    check("linestart_underrun", underrun, 0);

    // luma starvation mid-line sets the sticky underrun
    y_valid = 1'b0;
    pause_bad = 0;
    repeat (5) begin
      tick();
      if (dstrb || dout != 8'd80) pause_bad++;
    end
    y_valid = 1'b1;
    check("midline_held", pause_bad, 0);
    run_until(12, 50);
    check("midline_gap", strb_at(10) - strb_at(9), 7);
    check("midline_byte", out_at(10), 11);
    check("midline_underrun", underrun, 1);

    // reset mid line 1, then a 4:2:0 frame with chroma replay
    rst = 1'b0;
    #1;
    check("rstpulse_dout", dout, 0);
    check("rstpulse_dstrb", dstrb, 0);
    check("rstpulse_underrun", underrun, 0);
    check("rstpulse_y_ready", y_ready, 0);
    do_reset(1'b1);
    run_until(16, 200);
    for (int i = 0; i < 16; i++) check($sformatf("t420_byte%0d", i), out_at(i), exp_byte(i));
    gap_check("t420_period", 1, 15, 2);
    check("t420_dclr_first", (dclrq.size() > 0) ? dclrq[0] : -1, strb_at(0));
    check("t420_c_ready_line1", crdy_line1, 0);
    check("t420_chroma_taken", ccnt, 4);
    check("t420_underrun", underrun, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
